// File: rtl/lbd_pkg.sv
// LBD core shared definitions.
// Opcodes, halt encoding and fetch states.
package lbd_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int INSTR_WIDTH = 9;
  localparam int CNT_WIDTH   = 16;

  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR =
    9'b001_111111;

  typedef enum logic [2:0] {
    OP_LDI = 3'b000,
    OP_BRA = 3'b011,
    OP_BRB = 3'b101,
    OP_LD  = 3'b110,
    OP_ST  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, else bump unless saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// LBD front end: PC, fetch slicing, branch
// redirect and start/halt/done sequencing.
module instr_fetch #(
  parameter int PC_W    = lbd_pkg::PC_WIDTH,
  parameter int INSTR_W = lbd_pkg::INSTR_WIDTH,
  parameter logic [INSTR_W-1:0] HALT_INSTR =
    lbd_pkg::HALT_INSTR,
  parameter int CNT_W   = lbd_pkg::CNT_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               stall,
  input  logic               taken,
  input  logic [PC_W-1:0]    target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic [2:0]         opcode,
  output logic [INSTR_W-4:0] operand,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_cnt
);

  import lbd_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;

  logic is_run;
  logic is_halt;
  logic do_stall;
  logic do_halt;
  logic do_br;
  logic do_end;
  logic do_inc;
  logic cnt_clr;

  assign is_run  = (state_q == RUN);
  assign is_halt = (instr_in == HALT_INSTR);

  // one-hot RUN actions in priority order
  assign do_stall = stall;
  assign do_halt  = !stall && is_halt;
  assign do_br    = !stall && !is_halt && taken;
  assign do_end   = !stall && !is_halt && !taken
                    && (pc_q == '1);
  assign do_inc   = !stall && !is_halt && !taken
                    && (pc_q != '1);

  // next state, pc and done
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        unique case (1'b1)
          do_stall: ;
          do_halt, do_end: begin
            state_d = HALT;
            done_d  = 1'b1;
          end
          do_br:  pc_d = target;
          do_inc: pc_d = pc_q + PC_W'(1);
          default: ;
        endcase
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // fetch state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // restart clears, RUN counts, HALT freezes
  assign cnt_clr = Reset || (start && !is_run);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk_i (Clk),
    .clr_i (cnt_clr),
    .en_i  (is_run),
    .cnt_o (cycle_cnt)
  );

  // fields are live only in RUN
  always_comb begin
    opcode  = '0;
    operand = '0;
    if (is_run) begin
      opcode  = instr_in[INSTR_W-1 -: 3];
      operand = instr_in[INSTR_W-4:0];
    end
  end

  assign pc          = pc_q;
  assign done        = done_q;
  assign instr_valid = is_run;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the single-cycle LBD core.
- Owns the program counter (PC), addresses the instruction memory, and slices the fetched word into the opcode field for the control decoder and the operand field for the datapath.
- Consumes the resolved branch outcome coming back from the decoder/ALU.
- Sequences program start, halt and done for the top-level bench.

Parameters:
- PC_W, 10, program counter / instruction-memory address width
- INSTR_W, 9, instruction width; opcode is bits [INSTR_W-1:INSTR_W-3]
- HALT_INSTR, 9'b001_111111, full-word halt encoding
- CNT_W, 16, cycle counter width

Ports:
- Clk  in  1  clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse; begins or restarts a program at PC 0
- stall  in  1  hold the current instruction this cycle
- taken  in  1  branch resolved taken (decoder branch AND ALU condition)
- target  in  PC_W  absolute branch destination, valid with taken
- instr_in  in  INSTR_W  instruction-memory read data; combinational from pc
- pc  out  PC_W  instruction-memory address
- instr_valid  out  1  current opcode/operand are a live instruction
- opcode  out  3  to control decoder ALUOp
- operand  out  INSTR_W-3  low instruction bits to datapath
- done  out  1  program finished; held until the next start
- cycle_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, HALT. Reset has highest priority.
  - Reset value: state IDLE, pc 0, done 0, cycle_cnt 0.
  - Reset applies equally mid-program.
- instr_valid is 1 exactly when state is RUN. It is not gated by stall.
- opcode and operand:
  - In RUN they are instr_in sliced, combinational, zero latency.
  - Otherwise they are forced to 0.
  - Downstream must qualify writes with instr_valid, because opcode 000 is a live LDI.
- IDLE:
  - start=1 gives next cycle RUN, pc 0, cycle_cnt 0, done 0.
  - Otherwise hold.
- RUN, per rising edge, in this priority:
  1. stall=1: pc, state and done hold; taken and halt are ignored; cycle_cnt still increments.
  2. instr_in == HALT_INSTR: next state HALT, done 1, pc holds on the halt address. Halt wins over a simultaneous taken.
  3. taken=1: pc <= target.
  4. pc == 2^PC_W-1 (run off end of memory): next state HALT, done 1, pc holds. No wrap to 0.
  5. else pc <= pc+1.
- In RUN, start is ignored.
- HALT:
  - pc, done and cycle_cnt are frozen.
  - start=1 gives next cycle RUN, pc 0, done 0, cycle_cnt 0.
- cycle_cnt:
  - Increments by 1 on every edge spent in RUN, including stall cycles and the halt cycle itself.
  - Saturates at 2^CNT_W-1; no wrap.
- taken while stalled or outside RUN has no effect. target is don't-care when taken=0.
- Latency: a branch resolved in cycle N makes pc == target in cycle N+1 (single-cycle core, no delay slot).

Decomposition:
- Shared package lbd_pkg holds:
  - opcode enum: OP_LDI=3'b000, OP_BRA=3'b011, OP_BRB=3'b101, OP_LD=3'b110, OP_ST=3'b111.
  - HALT_INSTR constant.
  - fetch state enum {IDLE, RUN, HALT}.
  - Control uses the same opcode enum.
- One sub-module: sat_counter, a parameterised width, synchronous clear, enable and saturating counter. Used for cycle_cnt.
- PC next-state logic stays inline.

Test Plan:
- Straight line: Reset, start, memory 0..4 = non-halt with HALT_INSTR at 5 -> pc 0,1,2,3,4,5. done=1 from the cycle after pc=5; cycle_cnt=6; pc holds 5.
- Branch: taken=1, target=10'h040 at pc 3 -> next pc 0x040, then 0x041. taken while stall=1 at pc 3 -> pc stays 3.
- Halt vs branch: HALT_INSTR fetched with taken=1, target 0x100 -> HALT, pc unchanged, done=1.
- Stall: stall high 3 cycles at pc 2 -> pc stays 2, instr_valid stays 1, cycle_cnt +3. Release -> pc 3.
- Run-off-end/restart:
  - Memory of all non-halt words -> pc reaches 0x3FF, then HALT, done=1, no wrap.
  - A start pulse in HALT -> pc 0, done 0, cycle_cnt 0 next cycle.
- Reset mid-run at pc 7 -> next cycle IDLE, pc 0, done 0, instr_valid 0, opcode 0.
